st7735s_rx: RTL and testbench
=============================

Name: st7735s_rx

Overview:
- Synthesizable SPI receiver modelling the panel side of the ST7735S link driven by the st7735s write controller.
- Oversamples the 4-wire bus (SCL, SDA, D/CX, CSX) in the system clock and assembles MSB-first bytes.
- Presents each byte with its D/CX flag on a valid/ready handshake.
- Used as a loopback checker and as the front end of a future panel emulator.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each SPI input (min 2).
- FIFO_DEPTH, 4, entries when ST7735S_RX_FIFO_EN is defined; power of 2, min 2.

Ports:
- i_clk  in  1  system clock; SPI half-bit period must be ≥ 4 i_clk cycles.
- i_nrst  in  1  asynchronous active-low reset.
- i_spi_clk  in  1  SCL; idles low, data sampled on rising edge.
- i_spi_mosi  in  1  SDA.
- i_spi_dc  in  1  D/CX; 0 = command, 1 = argument/data.
- i_spi_ss  in  1  CSX, active low.
- i_ready  in  1  consumer accepts the byte when o_valid && i_ready.
- i_clr_err  in  1  one-cycle pulse; clears o_overrun.
- o_data  out  8  received byte.
- o_dc  out  1  D/CX value latched for o_data.
- o_valid  out  1  o_data/o_dc hold a byte.
- o_overrun  out  1  sticky: a byte was dropped.
- o_frame_err  out  1  one-cycle pulse: CSX rose mid-byte.
- o_busy  out  1  CSX (synchronized) is low.

Behaviour:
- Reset (async assert, sync deassert use): o_data=0x00, o_dc=0, o_valid=0, o_overrun=0, o_frame_err=0, o_busy=0, bit counter=0, state IDLE. All synchronizers reset to the idle bus levels: clk=0, ss=1, mosi=0, dc=0.
- Synchronization:
  - Each SPI input passes through SYNC_STAGES flops.
  - Edges are detected on the synchronized signal against a one-cycle-delayed copy.
  - No logic is clocked by i_spi_clk.
- FSM IDLE:
  - o_busy=0; SPI clock edges ignored.
  - Synchronized ss falling edge → SHIFT with bit_cnt=0 and shift register cleared.
- FSM SHIFT:
  - o_busy=1.
  - On each synchronized clk rising edge: shift in mosi (MSB first), bit_cnt+1.
  - On the 8th edge, D/CX is sampled (ST7735S samples D/CX with D0), bit_cnt wraps to 0, and byte_done pulses. State stays SHIFT, so multiple bytes per CSX assertion are supported.
  - ss rising edge → IDLE. If bit_cnt≠0, the partial byte is discarded and o_frame_err pulses for one cycle.
  - A clk edge and an ss rise in the same cycle: the edge is processed first, then the abort check uses the updated bit_cnt.
- Latency: o_valid rises on the i_clk edge after byte_done, i.e. SYNC_STAGES+2 i_clk cycles after the first i_clk edge that samples the raw 8th SCL rise.
- Handshake (no FIFO):
  - o_valid holds until o_valid && i_ready; o_data and o_dc are stable while o_valid=1.
  - A byte_done in the same cycle as acceptance loads the new byte, and o_valid stays 1.
  - A byte_done while o_valid=1 and i_ready=0 drops the new byte, keeps the old one, and sets o_overrun.
- o_overrun:
  - Cleared only by i_clr_err or reset.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-byte: everything returns to reset values immediately. After release, the receiver waits for a fresh ss falling edge even if CSX is already low.

Optional Feature:
- ST7735S_RX_FIFO_EN defined: output register is replaced by a FIFO_DEPTH-entry FIFO of {dc, data}.
  - o_valid = not empty; o_data/o_dc show the head entry (first-word fall-through).
  - Push and pop in the same cycle are both honoured, including at full.
  - Push when full without a pop drops the byte and sets o_overrun.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Not defined: single output register exactly as in Behaviour.

Decomposition:
- Package st7735s_pkg:
  - DC_CMD=1'b0, DC_DATA=1'b1.
  - Byte width 8.
  - FSM state encoding (IDLE, SHIFT).
  - Byte-plus-dc entry type, 9 bits.
- Sub-module st7735s_sync: parameterized SYNC_STAGES synchronizer with reset value, plus rise/fall pulse outputs; instantiated per SPI input (edge outputs used for clk and ss).

Test Plan:
- Drive CSX low, send byte 0x95 with dc=0 at a 1 MHz SPI rate (50 MHz i_clk), i_ready=1 → one o_valid pulse with o_data=0x95, o_dc=0; no errors.
- Within one CSX assertion, send 0x2A dc=0, then 0x00 and 0x7F with dc=1, i_ready=1 → three accepted bytes in that order with dc values 0,1,1.
- Raise CSX after 5 bits of 0xA5 → o_frame_err for exactly one cycle, no o_valid; a following full byte 0x3C is received correctly.
- Hold i_ready=0 and send 0x11 then 0x22 → o_data stays 0x11 and o_overrun=1. Pulse i_clr_err → o_overrun=0. Accepting then yields 0x11 only.
- Assert i_nrst mid-byte (after 3 bits), release while CSX is still low → all outputs at reset values, no byte produced until CSX toggles. Next byte 0xC3 is correct.
- With ST7735S_RX_FIFO_EN, i_ready=0, send 5 bytes 0x01..0x05 → 0x01..0x04 stored, o_overrun=1. Draining yields 0x01..0x04 in order, then o_valid=0.

Source files
------------

// File: rtl/st7735s_pkg.sv
// Shared types and constants for the ST7735S panel-side SPI receiver.
package st7735s_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(BYTE_W);

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic              dc;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] s, input logic b);
        return {s[BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/st7735s_sync.sv
// Multi-flop input synchronizer with registered rise/fall pulses.
// STAGES must be at least 2. Edges are suppressed until the chain has flushed after reset.
module st7735s_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic [STAGES:0]   r_warm;
    logic              r_rise;
    logic              r_fall;

    // r_warm keeps a pin already at its active level when reset releases from looking like an edge.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_warm <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_warm <= {r_warm[STAGES-1:0], 1'b1};
            r_rise <= r_warm[STAGES] &  r_sync[STAGES-1] & ~r_prev;
            r_fall <= r_warm[STAGES] & ~r_sync[STAGES-1] &  r_prev;
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/st7735s_rx.sv
// ST7735S panel-side SPI receiver: oversampled 4-wire bus to {dc, byte} valid/ready stream.
// Define ST7735S_RX_FIFO_EN to replace the single output register with a FIFO_DEPTH-entry FIFO.
module st7735s_rx
    import st7735s_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    input  logic              i_spi_dc,
    input  logic              i_spi_ss,
    input  logic              i_ready,
    input  logic              i_clr_err,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_dc,
    output logic              o_valid,
    output logic              o_overrun,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int N_SPI    = 4;
    localparam int IDX_CLK  = 0;
    localparam int IDX_MOSI = 1;
    localparam int IDX_DC   = 2;
    localparam int IDX_SS   = 3;
    // Idle bus levels: ss high, everything else low.
    localparam logic [N_SPI-1:0] SYNC_RST = 4'b1000;

    logic [N_SPI-1:0] w_raw;
    logic [N_SPI-1:0] w_sync;
    logic [N_SPI-1:0] w_rise;
    logic [N_SPI-1:0] w_fall;
    logic [6:0]       w_unused_sync;

    assign w_raw = {i_spi_ss, i_spi_dc, i_spi_mosi, i_spi_clk};

    generate
        for (genvar gi = 0; gi < N_SPI; gi++) begin : g_sync
            st7735s_sync #(
                .STAGES  (SYNC_STAGES),
                .RST_VAL (SYNC_RST[gi])
            ) u_sync (
                .i_clk  (i_clk),
                .i_nrst (i_nrst),
                .i_d    (w_raw[gi]),
                .o_q    (w_sync[gi]),
                .o_rise (w_rise[gi]),
                .o_fall (w_fall[gi])
            );
        end
    endgenerate

    assign w_unused_sync = {w_sync[IDX_CLK], w_sync[IDX_SS], w_rise[IDX_MOSI], w_rise[IDX_DC],
                            w_fall[IDX_CLK], w_fall[IDX_MOSI], w_fall[IDX_DC]};

    logic w_clk_rise;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_mosi;
    logic w_dc;

    assign w_clk_rise = w_rise[IDX_CLK];
    assign w_ss_rise  = w_rise[IDX_SS];
    assign w_ss_fall  = w_fall[IDX_SS];
    assign w_mosi     = w_sync[IDX_MOSI];
    assign w_dc       = w_sync[IDX_DC];

    rx_state_t         r_state,   w_state_next;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic [BYTE_W-1:0] r_shift,   w_shift_next;
    rx_entry_t         r_entry,   w_entry_next;
    logic              r_byte_done, w_byte_done;
    logic              r_frame_err, w_frame_err;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_entry     <= '0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_entry     <= w_entry_next;
            r_byte_done <= w_byte_done;
            r_frame_err <= w_frame_err;
        end
    end

    // A clock edge coinciding with CSX rising is shifted first, so a just-completed byte is kept.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_entry_next   = r_entry;
        w_byte_done    = 1'b0;
        w_frame_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_next   = SHIFT;
                    w_bit_cnt_next = '0;
                    w_shift_next   = '0;
                end
            end
            SHIFT: begin
                if (w_clk_rise) begin
                    w_shift_next = shift_in(r_shift, w_mosi);
                    if (r_bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        w_bit_cnt_next    = '0;
                        w_byte_done       = 1'b1;
                        w_entry_next.dc   = w_dc;
                        w_entry_next.data = w_shift_next;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end
                if (w_ss_rise) begin
                    w_state_next = IDLE;
                    w_frame_err  = (w_bit_cnt_next != '0);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_busy      = (r_state == SHIFT);
    assign o_frame_err = r_frame_err;

`ifdef ST7735S_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    rx_entry_t   r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overrun;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    rx_entry_t   w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    // A pop frees the slot in the same edge, so a push at full is still accepted.
    assign w_push  = r_byte_done && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (r_byte_done && !w_push) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_head    = w_empty ? rx_entry_t'('0) : r_mem[r_rd_ptr[AW-1:0]];
    assign o_data    = w_head.data;
    assign o_dc      = w_head.dc;
    assign o_valid   = !w_empty;
    assign o_overrun = r_overrun;
`else
    localparam int UNUSED_FIFO_DEPTH = FIFO_DEPTH;

    rx_entry_t r_out;
    logic      r_valid;
    logic      r_overrun;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_byte_done && (!r_valid || i_ready)) begin
                r_out   <= r_entry;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (r_byte_done && r_valid && !i_ready) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data    = r_out.data;
    assign o_dc      = r_out.dc;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_st7735s_rx.sv
// Randomized self-checking bench for st7735s_rx against a queue-based byte-stream model.
module tb_st7735s_rx;
    import st7735s_pkg::*;

    localparam int FIFO_DEPTH = 4;
`ifdef ST7735S_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       i_clk = 1'b0;
    logic       i_nrst;
    logic       i_spi_clk;
    logic       i_spi_mosi;
    logic       i_spi_dc;
    logic       i_spi_ss;
    logic       i_ready;
    logic       i_clr_err;
    logic [7:0] o_data;
    logic       o_dc;
    logic       o_valid;
    logic       o_overrun;
    logic       o_frame_err;
    logic       o_busy;

    always #10 i_clk = ~i_clk;

    st7735s_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_spi_clk   (i_spi_clk),
        .i_spi_mosi  (i_spi_mosi),
        .i_spi_dc    (i_spi_dc),
        .i_spi_ss    (i_spi_ss),
        .i_ready     (i_ready),
        .i_clr_err   (i_clr_err),
        .o_data      (o_data),
        .o_dc        (o_dc),
        .o_valid     (o_valid),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q[$];
    logic       exp_overrun = 1'b0;
    int         exp_frame = 0;
    int         got_frame = 0;
    int         n_accept = 0;
    logic [8:0] last_acc = '0;
    int         ready_mode = 1;
    int         pend_cnt = 0;
    int         half = 25;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ready: 0 = held low, 1 = held high, 2 = random with a bounded stall
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0: i_ready = 1'b0;
            1: i_ready = 1'b1;
            default: begin
                if (o_valid && !i_ready) pend_cnt++;
                else pend_cnt = 0;
                i_ready = (pend_cnt > 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
        endcase
    end

    logic       prev_hold = 1'b0;
    logic [8:0] prev_word = '0;
    logic       prev_ferr = 1'b0;
    logic [8:0] mon_word;

    always @(negedge i_clk) begin
        if (!i_nrst) begin
            prev_hold = 1'b0;
            prev_ferr = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, o_valid}, 32'd1);
                check("hold_word", {23'd0, o_dc, o_data}, {23'd0, prev_word});
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got dc=%0b data=0x%02h, required no byte", o_dc, o_data);
                end else begin
                    mon_word = exp_q.pop_front();
                    check("byte", {23'd0, o_dc, o_data}, {23'd0, mon_word});
                end
                last_acc = {o_dc, o_data};
                n_accept++;
            end else if (o_valid && exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got o_valid=1 data=0x%02h, required o_valid=0", o_data);
            end
            if (o_frame_err) begin
                got_frame++;
                if (prev_ferr) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_err_width: got pulse longer than 1 cycle, required 1 cycle");
                end
            end
            prev_hold = o_valid && !i_ready;
            prev_word = {o_dc, o_data};
            prev_ferr = o_frame_err;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic model_byte(input logic [7:0] d, input logic dc);
        if (ready_mode == 0 && exp_q.size() >= CAP) exp_overrun = 1'b1;
        else exp_q.push_back({dc, d});
    endtask

    task automatic send_bits(input logic [7:0] d, input logic dc, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            i_spi_mosi = d[7-i];
            i_spi_dc   = dc;
            wait_clk(half);
            i_spi_clk = 1'b1;
            wait_clk(half);
            i_spi_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic dc);
        model_byte(d, dc);
        send_bits(d, dc, 8);
    endtask

    task automatic cs_low();
        i_spi_ss = 1'b0;
        wait_clk(half);
    endtask

    task automatic cs_high();
        wait_clk(half);
        i_spi_ss = 1'b1;
        wait_clk(2 * half);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            wait_clk(1);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bytes outstanding, required 0", exp_q.size());
        end
        wait_clk(3);
    endtask

    initial begin
        #1_800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        i_nrst = 1'b0; i_spi_clk = 1'b0; i_spi_mosi = 1'b0; i_spi_dc = 1'b0;
        i_spi_ss = 1'b1; i_ready = 1'b1; i_clr_err = 1'b0;
        wait_clk(3);
        check("rst_data", {24'd0, o_data}, 32'h0);
        check("rst_dc", {31'd0, o_dc}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_overrun", {31'd0, o_overrun}, 32'd0);
        check("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        i_nrst = 1'b1;
        wait_clk(5);

        // single command byte
        cs_low();
        check("busy_in_frame", {31'd0, o_busy}, 32'd1);
        send_byte(8'h95, DC_CMD);
        cs_high();
        wait_drain();
        check("t1_word", {23'd0, last_acc}, 32'h095);
        check("t1_count", n_accept, 1);
        check("t1_busy_idle", {31'd0, o_busy}, 32'd0);
        check("t1_overrun", {31'd0, o_overrun}, 32'd0);

        // three bytes in one CSX assertion
        cs_low();
        send_byte(8'h2A, DC_CMD);
        send_byte(8'h00, DC_DATA);
        send_byte(8'h7F, DC_DATA);
        cs_high();
        wait_drain();
        check("t2_count", n_accept, 4);
        check("t2_last", {23'd0, last_acc}, 32'h17F);

        // aborted partial byte, then a good one
        cs_low();
        send_bits(8'hA5, DC_CMD, 5);
        exp_frame++;
        cs_high();
        check("t3_frame_err_cnt", got_frame, 1);
        check("t3_no_byte", n_accept, 4);
        cs_low();
        send_byte(8'h3C, DC_DATA);
        cs_high();
        wait_drain();
        check("t3_word", {23'd0, last_acc}, 32'h13C);

        // randomized frames, rates and back-pressure
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            half = $urandom_range(4, 12);
            cs_low();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) send_byte(8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                send_bits(8'($urandom), 1'($urandom), $urandom_range(1, 7));
                exp_frame++;
            end
            cs_high();
        end
        ready_mode = 1;
        wait_drain();
        check("rand_frame_err_cnt", got_frame, exp_frame);
        check("rand_overrun", {31'd0, o_overrun}, 32'd0);

        // overrun with consumer stalled
        half = 25;
        ready_mode = 0;
        wait_clk(3);
        cs_low();
        send_byte(8'h11, DC_CMD);
        send_byte(8'h22, DC_CMD);
        cs_high();
        wait_clk(10);
        check("ovr_head", {24'd0, o_data}, 32'h11);
        check("ovr_flag_model", {31'd0, o_overrun}, {31'd0, exp_overrun});
`ifdef ST7735S_RX_FIFO_EN
        check("ovr_flag", {31'd0, o_overrun}, 32'd0);
`else
        check("ovr_flag", {31'd0, o_overrun}, 32'd1);
`endif
        i_clr_err = 1'b1;
        wait_clk(1);
        i_clr_err = 1'b0;
        exp_overrun = 1'b0;
        wait_clk(1);
        check("ovr_cleared", {31'd0, o_overrun}, 32'd0);
        ready_mode = 1;
        wait_drain();
`ifdef ST7735S_RX_FIFO_EN
        check("ovr_last", {23'd0, last_acc}, 32'h022);
`else
        check("ovr_last", {23'd0, last_acc}, 32'h011);
`endif
        check("ovr_valid_after", {31'd0, o_valid}, 32'd0);

        // reset in the middle of a byte with CSX held low
        cs_low();
        send_bits(8'h5A, DC_DATA, 3);
        i_nrst = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_data", {24'd0, o_data}, 32'h0);
        check("mid_rst_overrun", {31'd0, o_overrun}, 32'd0);
        wait_clk(3);
        i_nrst = 1'b1;
        nb = n_accept;
        send_bits(8'h5A, DC_DATA, 5);
        wait_clk(20);
        check("post_rst_busy", {31'd0, o_busy}, 32'd0);
        check("post_rst_valid", {31'd0, o_valid}, 32'd0);
        check("post_rst_count", n_accept, nb);
        cs_high();
        cs_low();
        send_byte(8'hC3, DC_DATA);
        cs_high();
        wait_drain();
        check("post_rst_word", {23'd0, last_acc}, 32'h1C3);
        check("frame_err_total", got_frame, exp_frame);

`ifdef ST7735S_RX_FIFO_EN
        // fill past depth with consumer stalled
        ready_mode = 0;
        wait_clk(3);
        cs_low();
        for (int k = 1; k <= 5; k++) send_byte(8'(k), DC_DATA);
        cs_high();
        wait_clk(10);
        check("fifo_overrun", {31'd0, o_overrun}, 32'd1);
        check("fifo_overrun_model", {31'd0, o_overrun}, {31'd0, exp_overrun});
        check("fifo_head", {24'd0, o_data}, 32'h01);
        ready_mode = 1;
        wait_drain();
        check("fifo_last", {23'd0, last_acc}, 32'h104);
        check("fifo_empty", {31'd0, o_valid}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
